// File: rtl/uart_pkg.sv
// uart_pkg: shared word width, arbiter state encoding and default start timeout.
package uart_pkg;
  localparam int UART_DATA_W = 9;
  localparam int START_TIMEOUT_DEF = 16;
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search starting at ptr, wrapping modulo N_REQ.
module rr_picker #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             any_req
);
  logic [IW:0] idx;
  // Scan offsets from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    winner = '0;
    idx = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      idx = {1'b0, ptr} + (IW+1)'(j);
      idx = idx >= (IW+1)'(N_REQ) ? idx - (IW+1)'(N_REQ) : idx;
      if (req[idx[IW-1:0]]) winner = idx[IW-1:0];
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_transmitter among N_REQ byte sources.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_W = UART_DATA_W,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF,
  localparam int IW = $clog2(N_REQ),
  localparam int CW = $clog2(START_TIMEOUT) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_send,
  input  logic                    tx_busy,
  output logic [IW-1:0]           grant_id,
  output logic                    active,
  output logic                    err_timeout
);
  state_t            state, state_n;
  logic [IW-1:0]     rr_ptr, ptr_n, gid_n, winner;
  logic [CW-1:0]     cnt, cnt_n;
  logic [N_REQ-1:0]  ack_n;
  logic [DATA_W-1:0] data_n;
  logic              send_n, err_n, any_req;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req(req),
    .ptr(rr_ptr),
    .winner(winner),
    .any_req(any_req)
  );

  always_comb begin
    state_n = state;
    ack_n = '0;
    send_n = 1'b0;
    data_n = tx_data;
    gid_n = grant_id;
    ptr_n = rr_ptr;
    cnt_n = cnt;
    err_n = err_timeout;
    case (state)
      ST_IDLE:
        if (any_req && !tx_busy) begin
          state_n = ST_LAUNCH;
          ack_n = N_REQ'(1) << winner;
          send_n = 1'b1;
          data_n = req_data[int'(winner)*DATA_W +: DATA_W];
          gid_n = winner;
          ptr_n = (winner == IW'(N_REQ - 1)) ? '0 : winner + IW'(1);
        end
      ST_LAUNCH: begin
        cnt_n = '0;
        state_n = ST_WAIT_BUSY;
      end
      // A launch that never raises busy drops the word and flags a sticky error.
      ST_WAIT_BUSY:
        if (tx_busy) state_n = ST_WAIT_DONE;
        else if (cnt == CW'(START_TIMEOUT - 1)) begin
          err_n = 1'b1;
          state_n = ST_IDLE;
        end else cnt_n = cnt + CW'(1);
      ST_WAIT_DONE: state_n = tx_busy ? ST_WAIT_DONE : ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      ack <= '0;
      tx_send <= 1'b0;
      tx_data <= '0;
      grant_id <= '0;
      rr_ptr <= '0;
      cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_n;
      ack <= ack_n;
      tx_send <= send_n;
      tx_data <= data_n;
      grant_id <= gid_n;
      rr_ptr <= ptr_n;
      cnt <= cnt_n;
      err_timeout <= err_n;
    end
  end

  assign active = state != ST_IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven grant sequence plus timeout, foreign-busy and reset corners.
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 9;
  typedef struct {
    logic [N-1:0] r;
    logic [W-1:0] base;
    int           id;
  } vec_t;

  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] ack;
  logic [W-1:0] tx_data;
  logic tx_send, tx_busy, active, err_timeout;
  logic [1:0] grant_id;
  logic model_en = 1'b1, force_busy = 1'b0;
  int m_cnt = 0;
  int errors = 0, checks = 0;
  vec_t tbl[11];

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .START_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy), .grant_id(grant_id),
    .active(active), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises 2 cycles after send and stays high 20 cycles.
  always @(posedge clk) m_cnt <= tx_send ? 1 : (m_cnt == 0 || m_cnt == 22) ? 0 : m_cnt + 1;
  assign tx_busy = model_en ? (m_cnt >= 2 && m_cnt < 22) : force_busy;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic set_req(input logic [N-1:0] r, input logic [W-1:0] base);
    req = r;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = base + W'(i);
  endtask

  task automatic grant(input string nm, input logic [N-1:0] r, input logic [W-1:0] base, input int id);
    int n = 0;
    logic [W-1:0] ed;
    ed = base + W'(id);
    set_req(r, base);
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < 50);
    chk({nm, " latency"}, n, 1);
    chk({nm, " ack"}, ack, 32'(1) << id);
    chk({nm, " send"}, tx_send, 1);
    chk({nm, " data"}, tx_data, ed);
    chk({nm, " gid"}, grant_id, id);
    chk({nm, " active"}, active, 1);
  endtask

  task automatic frame(input string nm);
    int n = 0;
    logic extra = 1'b0;
    @(negedge clk);
    chk({nm, " pulse"}, {ack, tx_send}, 0);
    while (!tx_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " busy seen"}, tx_busy, 1);
    n = 0;
    while (tx_busy && n < 50) begin
      @(negedge clk);
      n++;
      extra |= (ack != '0) | tx_send;
    end
    chk({nm, " extra ack"}, extra, 0);
    chk({nm, " active hold"}, active, 1);
    @(negedge clk);
    chk({nm, " active fall"}, active, 0);
  endtask

  initial begin
    tbl[0]  = '{4'b0100, 9'h155, 2};
    tbl[1]  = '{4'b1111, 9'h100, 3};
    tbl[2]  = '{4'b1111, 9'h100, 0};
    tbl[3]  = '{4'b1111, 9'h100, 1};
    tbl[4]  = '{4'b1111, 9'h100, 2};
    tbl[5]  = '{4'b1111, 9'h100, 3};
    tbl[6]  = '{4'b1001, 9'h040, 0};
    tbl[7]  = '{4'b1001, 9'h040, 3};
    tbl[8]  = '{4'b0110, 9'h0AA, 1};
    tbl[9]  = '{4'b0011, 9'h1F0, 0};
    tbl[10] = '{4'b0011, 9'h1F0, 1};
    repeat (2) @(negedge clk);
    chk("rst outs", {ack, tx_send, tx_data, grant_id, active, err_timeout}, 0);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      grant($sformatf("v%0d", k), tbl[k].r, tbl[k].base, tbl[k].id);
      frame($sformatf("v%0d", k));
    end
    model_en = 1'b0;
    force_busy = 1'b0;
    grant("to", 4'b0010, 9'h0F0, 1);
    req = '0;
    repeat (16) @(negedge clk);
    chk("to err early", {err_timeout, active}, 2'b01);
    @(negedge clk);
    chk("to err set", {err_timeout, active}, 2'b10);
    repeat (6) @(negedge clk);
    model_en = 1'b1;
    grant("post_to", 4'b0001, 9'h020, 0);
    chk("err sticky", err_timeout, 1);
    frame("post_to");
    chk("err sticky2", err_timeout, 1);
    model_en = 1'b0;
    force_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("foreign hold", {ack, tx_send, active}, 0);
    end
    force_busy = 1'b0;
    model_en = 1'b1;
    grant("foreign", 4'b0001, 9'h033, 0);
    frame("foreign");
    grant("pre_rst", 4'b0100, 9'h0C0, 2);
    req = '0;
    repeat (5) @(negedge clk);
    chk("pre_rst wait_done", {active, tx_busy}, 2'b11);
    #2 reset = 1'b0;
    #1 chk("async rst", {ack, tx_send, tx_data, grant_id, active, err_timeout}, 0);
    model_en = 1'b0;
    force_busy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    model_en = 1'b1;
    grant("post_rst", 4'b1001, 9'h111, 0);
    frame("post_rst");
    grant("rr3", 4'b1000, 9'h0E0, 3);
    req = '0;
    frame("rr3");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
